// File: rtl/fault_mon_pkg.sv
// Shared definitions for the multi-channel drift/fault monitor.
//   - Severity level encodings reported on f_level.
//   - Per-channel reference state (no reference mean yet / have one).
//   - classify_level(): grades an absolute mean difference against the
//     four ascending thresholds.
package fault_mon_pkg;

    localparam logic [2:0] LVL_NONE = 3'd0;
    localparam logic [2:0] LVL_1    = 3'd1;
    localparam logic [2:0] LVL_2    = 3'd2;
    localparam logic [2:0] LVL_3    = 3'd3;
    localparam logic [2:0] LVL_4    = 3'd4;

    typedef enum logic {
        NO_REF   = 1'b0,
        HAVE_REF = 1'b1
    } ch_state_t;

    // Highest threshold reached wins; below thr1 is not a fault.
    function automatic logic [2:0] classify_level(input int d,
                                                  input int thr1,
                                                  input int thr2,
                                                  input int thr3,
                                                  input int thr4);
        logic [2:0] lvl;
        if (d >= thr4)      lvl = LVL_4;
        else if (d >= thr3) lvl = LVL_3;
        else if (d >= thr2) lvl = LVL_2;
        else if (d >= thr1) lvl = LVL_1;
        else                lvl = LVL_NONE;
        return lvl;
    endfunction

endpackage

// File: rtl/rr_arbiter_nc.sv
// Round-robin arbiter over NUM_CH request lines.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (pointer -> 0)
//   req          - request vector, one bit per channel
//   en           - grant is consumed this edge; pointer advances on a grant
//   grant        - one-hot grant (combinational)
//   grant_idx    - index of the granted channel (combinational)
//   grant_vld    - at least one request present
// The search starts one past the most recently granted channel, so a
// channel that was just served goes to the back of the line.
module rr_arbiter_nc #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_vld
);

    logic [CH_W-1:0] last_q;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_q) + i) % NUM_CH;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = CH_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else if (en && grant_vld) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/fault_monitor_mc.sv
// Multi-channel drift/fault monitor.
// Each channel's samples are averaged over windows of 2**WIN_LOG2 samples;
// every completed window mean is compared with the previous mean of the same
// channel, the absolute difference is graded into levels 1..4, and graded
// faults are reported one at a time through a valid/ready port with
// round-robin fairness across channels.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   s_valid, s_data,
//   s_ch              - sample strobe, unsigned sample, channel index
//                       (indices >= NUM_CH are ignored; never backpressured)
//   f_valid, f_ready  - fault report handshake
//   f_level, f_ch     - severity (1..4) and channel of the current report
//   overrun           - sticky per-channel flag: a fault was merged into one
//                       still waiting to be reported
module fault_monitor_mc
    import fault_mon_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int WIN_LOG2 = 2,
    parameter int THR1     = 10,
    parameter int THR2     = 25,
    parameter int THR3     = 50,
    parameter int THR4     = 100,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]   s_ch,
    output logic              f_valid,
    input  logic              f_ready,
    output logic [2:0]        f_level,
    output logic [CH_W-1:0]   f_ch,
    output logic [NUM_CH-1:0] overrun
);

    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WIN_LOG2) - 1);

    if (THR1 > THR2 || THR2 > THR3 || THR3 > THR4) begin : g_bad_thr
        $error("fault_monitor_mc: thresholds must satisfy THR1<=THR2<=THR3<=THR4");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_nch
        $error("fault_monitor_mc: NUM_CH must be in 2..16");
    end

    // |a - b| through a one-bit-wider signed difference; the result always
    // fits back into DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < 0) ? DATA_W'(-diff) : DATA_W'(diff);
    endfunction

    function automatic logic [2:0] lvl_max(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [ACC_W-1:0]  acc_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [DATA_W-1:0] ref_q   [NUM_CH];
    ch_state_t         st_q    [NUM_CH];
    ch_state_t         st_d    [NUM_CH];

    logic              accept;
    logic [CH_W-1:0]   ch_sel;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] mean;
    logic              last_smp;
    logic              cmp_load;

    logic              vld_p0;
    logic [DATA_W-1:0] new_p0;
    logic [DATA_W-1:0] ref_p0;
    logic [CH_W-1:0]   ch_p0;
    logic [2:0]        lvl_p0;
    logic              fault_p0;

    logic [NUM_CH-1:0] pend_q;
    logic [2:0]        plevel_q [NUM_CH];

    logic              out_load;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;

    // ---- Sample intake: accumulate, detect window completion ----
    assign accept   = s_valid && (int'(s_ch) < NUM_CH);
    assign ch_sel   = accept ? s_ch : '0;
    assign sum      = acc_q[ch_sel] + ACC_W'(s_data);
    assign mean     = DATA_W'(sum >> WIN_LOG2);
    assign last_smp = accept && (cnt_q[ch_sel] == LAST_CNT);
    assign cmp_load = last_smp && (st_q[ch_sel] == HAVE_REF);

    always_comb begin
        st_d = st_q;
        if (last_smp && st_q[ch_sel] == NO_REF) begin
            st_d[ch_sel] = HAVE_REF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                ref_q[i] <= '0;
                st_q[i]  <= NO_REF;
            end
            vld_p0 <= 1'b0;
        end else begin
            st_q   <= st_d;
            vld_p0 <= cmp_load;
            if (accept) begin
                if (last_smp) begin
                    acc_q[ch_sel] <= '0;
                    cnt_q[ch_sel] <= '0;
                    // Sliding reference: every completed mean becomes the
                    // reference for the next window.
                    ref_q[ch_sel] <= mean;
                end else begin
                    acc_q[ch_sel] <= sum;
                    cnt_q[ch_sel] <= cnt_q[ch_sel] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmp_load) begin
            new_p0 <= mean;
            ref_p0 <= ref_q[ch_sel];
            ch_p0  <= ch_sel;
        end
    end

    // ---- Compare stage: grade |new - ref| ----
    assign lvl_p0   = classify_level(int'(abs_diff(new_p0, ref_p0)), THR1, THR2, THR3, THR4);
    assign fault_p0 = vld_p0 && (lvl_p0 != LVL_NONE);

    // ---- Pending faults and output register ----
    assign out_load = !f_valid || f_ready;

    rr_arbiter_nc #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (pend_q),
        .en        (out_load),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            overrun <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                plevel_q[i] <= LVL_NONE;
            end
            f_valid <= 1'b0;
            f_level <= LVL_NONE;
            f_ch    <= '0;
        end else begin
            if (out_load) begin
                f_valid <= gnt_vld;
                f_level <= gnt_vld ? plevel_q[gnt_idx] : LVL_NONE;
                f_ch    <= gnt_vld ? gnt_idx : '0;
                pend_q  <= pend_q & ~gnt_oh;
            end
            if (fault_p0) begin
                // A fault landing on a channel that is still waiting (and not
                // being taken this very edge) is merged at the worse level.
                if (pend_q[ch_p0] && !(out_load && gnt_oh[ch_p0])) begin
                    plevel_q[ch_p0] <= lvl_max(plevel_q[ch_p0], lvl_p0);
                    overrun[ch_p0]  <= 1'b1;
                end else begin
                    pend_q[ch_p0]   <= 1'b1;
                    plevel_q[ch_p0] <= lvl_p0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fault_monitor_mc.sv
// Testbench for fault_monitor_mc (5 channels so that an out-of-range channel
// index is representable on s_ch).
module tb_fault_monitor_mc;

    localparam int DATA_W   = 8;
    localparam int NUM_CH   = 5;
    localparam int CH_W     = 3;
    localparam int WIN_LOG2 = 2;
    localparam int WIN      = 1 << WIN_LOG2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic [CH_W-1:0]   s_ch = '0;
    logic              f_valid;
    logic              f_ready = 1'b0;
    logic [2:0]        f_level;
    logic [CH_W-1:0]   f_ch;
    logic [NUM_CH-1:0] overrun;

    int n_checks = 0;
    int n_err    = 0;

    fault_monitor_mc #(
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .WIN_LOG2 (WIN_LOG2),
        .THR1     (10),
        .THR2     (25),
        .THR3     (50),
        .THR4     (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ch    (s_ch),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f_level (f_level),
        .f_ch    (f_ch),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_samples [NUM_CH][$];
    bit m_has_ref [NUM_CH];
    int m_ref     [NUM_CH];
    bit m_cmp_v;
    int m_cmp_ch, m_cmp_lvl;
    bit m_pend    [NUM_CH];
    int m_plvl    [NUM_CH];
    bit m_ovr     [NUM_CH];
    int m_last;
    bit m_fv;
    int m_fl, m_fc;

    function automatic int grade(input int d);
        if (d >= 100) return 4;
        if (d >= 50)  return 3;
        if (d >= 25)  return 2;
        if (d >= 10)  return 1;
        return 0;
    endfunction

    task automatic model_update(input bit v, input int d, input int c,
                                input bit rdy, input bit rst);
        int g, k, total, mn, diff;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_samples[i].delete();
                m_has_ref[i] = 0; m_ref[i] = 0;
                m_pend[i] = 0; m_plvl[i] = 0; m_ovr[i] = 0;
            end
            m_cmp_v = 0; m_last = 0; m_fv = 0; m_fl = 0; m_fc = 0;
            return;
        end
        // output register / round-robin pick
        if (!m_fv || rdy) begin
            g = -1;
            for (int i = 1; i <= NUM_CH; i++) begin
                k = (m_last + i) % NUM_CH;
                if (g < 0 && m_pend[k]) g = k;
            end
            if (g >= 0) begin
                m_fv = 1; m_fl = m_plvl[g]; m_fc = g; m_pend[g] = 0; m_last = g;
            end else begin
                m_fv = 0; m_fl = 0; m_fc = 0;
            end
        end
        // graded result from the previous window completion
        if (m_cmp_v && m_cmp_lvl > 0) begin
            if (m_pend[m_cmp_ch]) begin
                if (m_cmp_lvl > m_plvl[m_cmp_ch]) m_plvl[m_cmp_ch] = m_cmp_lvl;
                m_ovr[m_cmp_ch] = 1;
            end else begin
                m_pend[m_cmp_ch] = 1; m_plvl[m_cmp_ch] = m_cmp_lvl;
            end
        end
        m_cmp_v = 0;
        // sample intake
        if (v && c < NUM_CH) begin
            m_samples[c].push_back(d);
            if (m_samples[c].size() == WIN) begin
                total = 0;
                foreach (m_samples[c][j]) total += m_samples[c][j];
                mn = total / WIN;
                if (m_has_ref[c]) begin
                    diff = (mn > m_ref[c]) ? mn - m_ref[c] : m_ref[c] - mn;
                    m_cmp_v = 1; m_cmp_ch = c; m_cmp_lvl = grade(diff);
                end
                m_has_ref[c] = 1;
                m_ref[c] = mn;
                m_samples[c].delete();
            end
        end
    endtask

    // ---------------- drivers / checkers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input int d, input int c, input bit rdy, input bit rst);
        logic [NUM_CH-1:0] ovr_exp;
        s_valid = v;
        s_data  = DATA_W'(d);
        s_ch    = CH_W'(c);
        f_ready = rdy;
        reset   = rst;
        @(posedge clk);
        model_update(v, d, c, rdy, rst);
        #1;
        for (int i = 0; i < NUM_CH; i++) ovr_exp[i] = m_ovr[i];
        n_checks++;
        if (f_valid !== m_fv || int'(f_level) != m_fl || int'(f_ch) != m_fc || overrun !== ovr_exp) begin
            n_err++;
            $display("FAIL model: got v=%0b lvl=%0d ch=%0d ovr=%b, expected v=%0b lvl=%0d ch=%0d ovr=%b (t=%0t)",
                     f_valid, f_level, f_ch, overrun, m_fv, m_fl, m_fc, ovr_exp, $time);
        end
    endtask

    task automatic feed(input int c, input int d, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, d, c, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    typedef struct {
        bit v;
        int d;
        int c;
        bit rdy;
        bit ev;
        int el;
        int ec;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // reset state
        do_reset();
        do_reset();
        chk("reset_f_valid", int'(f_valid), 0);
        chk("reset_f_level", int'(f_level), 0);
        chk("reset_f_ch",    int'(f_ch),    0);
        chk("reset_overrun", int'(overrun), 0);

        // ch0: ref 100 then mean 140 -> level 2, two edges after 8th sample
        for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 100, 0, 1'b1, 1'b0, 0, 0};
        for (int i = 4; i < 8; i++) tbl[i] = '{1'b1, 140, 0, 1'b1, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 0, 0, 1'b1, 1'b0, 0, 0};
        tbl[9]  = '{1'b0, 0, 0, 1'b1, 1'b1, 2, 0};
        tbl[10] = '{1'b0, 0, 0, 1'b1, 1'b0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), int'(f_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_level", i), int'(f_level), tbl[i].el);
                chk($sformatf("tbl%0d_ch", i),    int'(f_ch),    tbl[i].ec);
            end
        end

        // ch2: equal windows give nothing, jump 10 -> 200 gives level 4
        do_reset();
        feed(2, 10, 4, 1'b1);
        feed(2, 10, 4, 1'b1);
        idle(3, 1'b1);
        chk("ch2_no_report", int'(f_valid), 0);
        feed(2, 200, 4, 1'b1);
        idle(1, 1'b1);
        chk("ch2_lat1_valid", int'(f_valid), 0);
        idle(1, 1'b1);
        chk("ch2_valid", int'(f_valid), 1);
        chk("ch2_level", int'(f_level), 4);
        chk("ch2_ch",    int'(f_ch),    2);
        idle(1, 1'b1);
        chk("ch2_drop", int'(f_valid), 0);

        // round-robin order: ch4 occupies output, ch3 and ch1 wait
        do_reset();
        feed(1, 0, 4, 1'b0);
        feed(3, 0, 4, 1'b0);
        feed(4, 0, 4, 1'b0);
        feed(4, 20, 4, 1'b0);
        idle(2, 1'b0);
        chk("rr1_hold_ch", int'(f_ch), 4);
        feed(3, 60, 3, 1'b0);
        feed(1, 15, 3, 1'b0);
        feed(3, 60, 1, 1'b0);
        feed(1, 15, 1, 1'b0);
        idle(2, 1'b0);
        chk("rr1_still_ch4", int'(f_ch), 4);
        idle(1, 1'b1);
        chk("rr1_first_ch",  int'(f_ch), 1);
        chk("rr1_first_lvl", int'(f_level), 1);
        idle(1, 1'b1);
        chk("rr1_second_ch",  int'(f_ch), 3);
        chk("rr1_second_lvl", int'(f_level), 3);
        idle(1, 1'b1);
        chk("rr1_drop", int'(f_valid), 0);
        // now ch2 occupies output, so rotation favours ch3 before ch1
        feed(2, 0, 4, 1'b0);
        feed(2, 30, 4, 1'b0);
        idle(2, 1'b0);
        chk("rr2_hold_ch", int'(f_ch), 2);
        feed(3, 0, 3, 1'b0);
        feed(1, 0, 3, 1'b0);
        feed(3, 0, 1, 1'b0);
        feed(1, 0, 1, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        chk("rr2_first_ch", int'(f_ch), 3);
        idle(1, 1'b1);
        chk("rr2_second_ch", int'(f_ch), 1);
        idle(1, 1'b1);
        chk("rr2_drop", int'(f_valid), 0);

        // merge while pending: level 1 held, level 1 pending, then level 4
        do_reset();
        feed(1, 0, 4, 1'b0);
        feed(1, 15, 4, 1'b0);
        idle(2, 1'b0);
        chk("ovr_first_lvl", int'(f_level), 1);
        feed(1, 0, 4, 1'b0);
        feed(1, 120, 4, 1'b0);
        idle(2, 1'b0);
        chk("ovr_held_valid", int'(f_valid), 1);
        chk("ovr_held_lvl",   int'(f_level), 1);
        chk("ovr_flag",       int'(overrun), 2);
        idle(1, 1'b1);
        chk("ovr_next_ch",  int'(f_ch), 1);
        chk("ovr_next_lvl", int'(f_level), 4);
        idle(1, 1'b1);
        chk("ovr_drop",   int'(f_valid), 0);
        chk("ovr_sticky", int'(overrun), 2);

        // reset in the middle of a window discards reference and partials
        feed(0, 0, 4, 1'b1);
        feed(0, 200, 3, 1'b1);
        do_reset();
        chk("mid_rst_valid",   int'(f_valid), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        feed(0, 200, 4, 1'b1);
        idle(3, 1'b1);
        chk("mid_rst_no_report", int'(f_valid), 0);

        // out-of-range channel indices leave every channel untouched
        do_reset();
        feed(0, 0, 4, 1'b1);
        feed(0, 200, 3, 1'b1);
        feed(5, 0, 1, 1'b1);
        feed(6, 0, 1, 1'b1);
        feed(7, 0, 1, 1'b1);
        idle(2, 1'b1);
        chk("bad_ch_quiet", int'(f_valid), 0);
        feed(0, 200, 1, 1'b1);
        idle(2, 1'b1);
        chk("bad_ch_valid", int'(f_valid), 1);
        chk("bad_ch_lvl",   int'(f_level), 4);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rst, v, rdy;
            int c, d;
            rst = ($urandom_range(0, 799) == 0);
            v   = ($urandom_range(0, 9) < 8);
            c   = $urandom_range(0, 6);
            d   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(95, 105);
            rdy = ($urandom_range(0, 9) < 7);
            step(v, d, c, rdy, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
